// File: rtl/sr_cmd_sequencer.sv
// Command sequencer ahead of an SR flip-flop: queues set/clear requests and issues
// mutually exclusive single-cycle s/r pulses separated by a programmable idle gap.
module sr_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_req,
  input  logic                   clr_req,
  output logic                   s,
  output logic                   r,
  output logic                   q_mirror,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   busy,
  output logic                   conflict,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state, state_nx;
  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    hold_cnt, hold_cnt_nx;
  logic          s_nx, r_nx, mirror_nx;
  logic          pop, push_req, push_ok, head;

  assign head     = mem[rd_ptr];
  assign push_req = set_req ^ clr_req;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = push_req && ((pending != FULL) || pop);
  assign busy     = (state != IDLE) || (pending != '0);

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    mirror_nx   = q_mirror;
    s_nx        = 1'b0;
    r_nx        = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          pop = 1'b1;
          // Commands that would not change q are dropped without a pulse or gap.
          if (head != q_mirror) begin
            state_nx = ISSUE;
            s_nx     = head;
            r_nx     = ~head;
          end
        end
      end
      ISSUE: begin
        mirror_nx = s;
        if (GAP > 0) begin
          state_nx    = HOLD;
          hold_cnt_nx = 4'(GAP - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt == 4'd0) begin
          state_nx = IDLE;
        end else begin
          hold_cnt_nx = hold_cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      s        <= 1'b0;
      r        <= 1'b0;
      q_mirror <= 1'b0;
      conflict <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      s        <= s_nx;
      r        <= r_nx;
      q_mirror <= mirror_nx;
      conflict <= set_req & clr_req;
      overflow <= overflow | (push_req & ~push_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= set_req;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   pending <= pending + (AW+1)'(1);
        2'b01:   pending <= pending - (AW+1)'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Randomized, scoreboard-checked bench for sr_cmd_sequencer; the reference model works
// on command queues and edge numbers rather than on FSM states.
module tb_sr_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          set_req = 1'b0;
  logic          clr_req = 1'b0;
  logic          s, r, q_mirror, busy, conflict, overflow;
  logic [PW-1:0] pending;

  sr_cmd_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .q_mirror(q_mirror), .pending(pending),
    .busy(busy), .conflict(conflict), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_set;
    int edge_no;
  } pulse_t;

  int     checks = 0;
  int     fails = 0;
  pulse_t exp_q[$];
  bit     model_q[$];
  int     edge_n = 0;
  int     ready_edge = 0;
  int     mirror_upd_edge = -1;
  bit     mirror_upd_val;
  bit     logic_mirror;
  bit     q_exp;
  bit     conflict_exp;
  bit     overflow_exp;

  task automatic check_value(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  function automatic void model_reset();
    model_q.delete();
    exp_q.delete();
    q_exp           = 1'b0;
    logic_mirror    = 1'b0;
    mirror_upd_edge = -1;
    ready_edge      = edge_n;
    conflict_exp    = 1'b0;
    overflow_exp    = 1'b0;
  endfunction

  // Next command may leave the queue at ready_edge; an issued pulse reserves 2+GAP edges.
  function automatic void model_step(input bit sreq, input bit creq);
    bit head;
    edge_n++;
    if (mirror_upd_edge == edge_n) q_exp = mirror_upd_val;
    if (edge_n >= ready_edge && model_q.size() > 0) begin
      head = model_q.pop_front();
      if (head != logic_mirror) begin
        exp_q.push_back('{is_set: head, edge_no: edge_n});
        logic_mirror    = head;
        mirror_upd_edge = edge_n + 1;
        mirror_upd_val  = head;
        ready_edge      = edge_n + 2 + GAP;
      end else begin
        ready_edge = edge_n + 1;
      end
    end
    conflict_exp = sreq & creq;
    if (sreq ^ creq) begin
      if (model_q.size() < DEPTH) model_q.push_back(sreq);
      else overflow_exp = 1'b1;
    end
  endfunction

  task automatic drive_cycle(input bit sreq, input bit creq);
    set_req = sreq;
    clr_req = creq;
    @(posedge clk);
    model_step(sreq, creq);
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2;
    reset   = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    model_reset();
    #1;
    check_value("rst_s", s, 0);
    check_value("rst_r", r, 0);
    check_value("rst_q_mirror", q_mirror, 0);
    check_value("rst_pending", int'(pending), 0);
    check_value("rst_overflow", overflow, 0);
    check_value("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: per-cycle state against the model, pulses against the scoreboard queue.
  always @(negedge clk) begin
    pulse_t p;
    if (!reset) begin
      check_value("s_and_r", int'(s & r), 0);
      if (s || r) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_pulse", 1, 0);
        end else begin
          p = exp_q.pop_front();
          check_value("pulse_type", s, p.is_set);
          check_value("pulse_edge", edge_n, p.edge_no);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].edge_no < edge_n)
        check_value("missed_pulse_edge", edge_n, exp_q.pop_front().edge_no);
      check_value("pending", int'(pending), model_q.size());
      check_value("q_mirror", q_mirror, q_exp);
      check_value("busy", busy, int'((edge_n < ready_edge - 1) || (model_q.size() != 0)));
      check_value("conflict", conflict, conflict_exp);
      check_value("overflow", overflow, overflow_exp);
    end
  end

  initial begin
    int pick;
    model_reset();
    repeat (2) @(negedge clk);
    check_value("init_s", s, 0);
    check_value("init_r", r, 0);
    check_value("init_q_mirror", q_mirror, 0);
    check_value("init_pending", int'(pending), 0);
    check_value("init_busy", busy, 0);
    check_value("init_conflict", conflict, 0);
    check_value("init_overflow", overflow, 0);
    reset = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b0);

    drive_cycle(1'b1, 1'b0);
    repeat (GAP + 4) drive_cycle(1'b0, 1'b0);
    check_value("mirror_after_set", q_mirror, 1);

    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    repeat (GAP + 8) drive_cycle(1'b0, 1'b0);
    check_value("mirror_after_redundant", q_mirror, 0);

    repeat (8) drive_cycle(1'b0, 1'b1);
    repeat (4) drive_cycle(1'b0, 1'b0);

    drive_cycle(1'b1, 1'b1);
    repeat (3) drive_cycle(1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      drive_cycle(i % 2 == 0, i % 2 == 1);
      repeat (GAP + 1) drive_cycle(1'b0, 1'b0);
    end
    repeat (10) drive_cycle(1'b0, 1'b0);

    for (int i = 0; i < 12; i++) drive_cycle(i % 2 == 0, i % 2 == 1);
    repeat (40) drive_cycle(1'b0, 1'b0);
    check_value("overflow_sticky", overflow, 1);

    drive_cycle(1'b0, 1'b1);
    repeat (GAP + 6) drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    check_value("s_before_reset", s, 1);
    reset_mid();
    repeat (3) drive_cycle(1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid();
      pick = $urandom_range(0, 9);
      drive_cycle(pick <= 2 || pick == 6, (pick >= 3 && pick <= 5) || pick == 6);
    end
    repeat (30) drive_cycle(1'b0, 1'b0);
    check_value("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
